bmu_depunct: RTL and testbench

- Branch-metric front end of the Viterbi decoder, directly upstream of the path-metric unit.
- Accepts a stream of soft-decision code symbols, one per beat, and reinserts erasures for punctured rates 1/2, 2/3 and 3/4.
- Per trellis step, computes the branch metrics of all 64 states for input bit 0 and input bit 1, then presents them with a one-cycle valid pulse.
- Code: K=7, generators G0=171 octal (7'b1111001), G1=133 octal (7'b1011011).

---
 rtl/bmu_depunct.sv | 151 +++++++++++++++
 tb/tb_bmu_depunct.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmu_depunct.sv
// Viterbi branch-metric front end: depunctures soft symbols into trellis steps and
// emits registered bit-0/bit-1 branch metrics for every state with a one-cycle valid.
module bmu_depunct #(
  parameter int STATES_N  = 64,
  parameter int SOFT_BITS = 3,
  parameter int BM_BITS   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [1:0]                  rate_i,
  input  logic [SOFT_BITS-1:0]        sym_i,
  input  logic                        sym_valid_i,
  output logic                        sym_ready_o,
  output logic [STATES_N*BM_BITS-1:0] bm0_o,
  output logic [STATES_N*BM_BITS-1:0] bm1_o,
  output logic                        valid_o
);

  localparam int                   SR_BITS = $clog2(STATES_N);
  localparam logic [SR_BITS:0]     G0      = 7'b1111001;
  localparam logic [SR_BITS:0]     G1      = 7'b1011011;
  localparam logic [SOFT_BITS-1:0] SYM_MAX = '1;

  typedef enum logic {SLOT_EMPTY, SLOT_C1_PEND} slot_e;

  slot_e                       slot_reg, slot_next;
  logic [1:0]                  phase_reg, phase_next;
  logic [1:0]                  rate_reg, rate_next, rate_eff;
  logic [SOFT_BITS-1:0]        hold_reg, hold_next;
  logic [SOFT_BITS-1:0]        s0_reg, s0_next, s1_reg, s1_next;
  logic                        e0_reg, e0_next, e1_reg, e1_next;
  logic                        ready_reg, step_ready_reg, valid_reg;
  logic                        accept, keep0, keep1, last_phase, complete;
  logic [STATES_N*BM_BITS-1:0] bm0_reg, bm1_reg, bm0_calc, bm1_calc;

  assign sym_ready_o = ready_reg & ~flush_i;
  assign accept      = sym_valid_i & sym_ready_o;
  assign bm0_o       = bm0_reg;
  assign bm1_o       = bm1_reg;
  assign valid_o     = valid_reg;

  always_comb begin
    // The live rate_i only matters at a pattern boundary; otherwise the latched rate rules.
    rate_eff   = (phase_reg == 2'd0 && slot_reg == SLOT_EMPTY) ? rate_i : rate_reg;
    keep0      = 1'b1;
    keep1      = 1'b1;
    last_phase = 1'b1;
    case (rate_eff)
      2'b01: begin
        keep1      = (phase_reg == 2'd0);
        last_phase = (phase_reg == 2'd1);
      end
      2'b10: begin
        keep0      = (phase_reg != 2'd1);
        keep1      = (phase_reg != 2'd2);
        last_phase = (phase_reg == 2'd2);
      end
      default: ;
    endcase

    slot_next  = slot_reg;
    phase_next = phase_reg;
    rate_next  = rate_reg;
    hold_next  = hold_reg;
    s0_next    = s0_reg;
    s1_next    = s1_reg;
    e0_next    = e0_reg;
    e1_next    = e1_reg;
    complete   = 1'b0;

    if (flush_i) begin
      slot_next  = SLOT_EMPTY;
      phase_next = 2'd0;
    end else if (accept) begin
      if (phase_reg == 2'd0 && slot_reg == SLOT_EMPTY) rate_next = rate_eff;
      if (slot_reg == SLOT_C1_PEND) begin
        complete = 1'b1;
        s0_next  = hold_reg;
        s1_next  = sym_i;
        e0_next  = 1'b0;
        e1_next  = 1'b0;
      end else if (keep0 && keep1) begin
        hold_next = sym_i;
        slot_next = SLOT_C1_PEND;
      end else begin
        complete = 1'b1;
        s0_next  = sym_i;
        s1_next  = sym_i;
        e0_next  = ~keep0;
        e1_next  = ~keep1;
      end
      if (complete) begin
        slot_next  = SLOT_EMPTY;
        phase_next = last_phase ? 2'd0 : phase_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_reg       <= SLOT_EMPTY;
      phase_reg      <= '0;
      rate_reg       <= '0;
      hold_reg       <= '0;
      s0_reg         <= '0;
      s1_reg         <= '0;
      e0_reg         <= 1'b0;
      e1_reg         <= 1'b0;
      ready_reg      <= 1'b0;
      step_ready_reg <= 1'b0;
      valid_reg      <= 1'b0;
      bm0_reg        <= '0;
      bm1_reg        <= '0;
    end else begin
      slot_reg       <= slot_next;
      phase_reg      <= phase_next;
      rate_reg       <= rate_next;
      hold_reg       <= hold_next;
      s0_reg         <= s0_next;
      s1_reg         <= s1_next;
      e0_reg         <= e0_next;
      e1_reg         <= e1_next;
      ready_reg      <= 1'b1;
      step_ready_reg <= complete;
      valid_reg      <= step_ready_reg;
      if (step_ready_reg) begin
        bm0_reg <= bm0_calc;
        bm1_reg <= bm1_calc;
      end
    end
  end

  function automatic logic [SOFT_BITS-1:0] metric(input logic code,
                                                  input logic [SOFT_BITS-1:0] s,
                                                  input logic erased);
    if (erased) return '0;
    return code ? SYM_MAX - s : s;
  endfunction

  // Expected code bits are constants per state, so each metric reduces to a mux and an adder.
  for (genvar gi = 0; gi < STATES_N; gi++) begin : g_state
    localparam logic [SR_BITS:0] R0 = {1'b0, SR_BITS'(gi)};
    localparam logic [SR_BITS:0] R1 = {1'b1, SR_BITS'(gi)};
    assign bm0_calc[gi*BM_BITS +: BM_BITS] =
        BM_BITS'(metric(^(R0 & G0), s0_reg, e0_reg)) + BM_BITS'(metric(^(R0 & G1), s1_reg, e1_reg));
    assign bm1_calc[gi*BM_BITS +: BM_BITS] =
        BM_BITS'(metric(^(R1 & G0), s0_reg, e0_reg)) + BM_BITS'(metric(^(R1 & G1), s1_reg, e1_reg));
  end

endmodule

// File: tb/tb_bmu_depunct.sv
// Scoreboard bench for bmu_depunct: a reference depuncturer predicts each trellis step,
// and every valid_o pulse is checked for timing and against all 64 golden metric pairs.
module tb_bmu_depunct;
  localparam int STATES_N  = 64;
  localparam int SOFT_BITS = 3;
  localparam int BM_BITS   = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        flush_i;
  logic [1:0]                  rate_i;
  logic [SOFT_BITS-1:0]        sym_i;
  logic                        sym_valid_i;
  logic                        sym_ready_o;
  logic [STATES_N*BM_BITS-1:0] bm0_o;
  logic [STATES_N*BM_BITS-1:0] bm1_o;
  logic                        valid_o;

  bmu_depunct #(.STATES_N(STATES_N), .SOFT_BITS(SOFT_BITS), .BM_BITS(BM_BITS)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .rate_i     (rate_i),
    .sym_i      (sym_i),
    .sym_valid_i(sym_valid_i),
    .sym_ready_o(sym_ready_o),
    .bm0_o      (bm0_o),
    .bm1_o      (bm1_o),
    .valid_o    (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int     s0;
    bit     e0;
    int     s1;
    bit     e1;
    longint at;
  } step_t;

  step_t  sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     pulses = 0;
  longint cyc    = 0;
  int     m_phase = 0;
  bit     m_held  = 0;
  int     m_hsym  = 0;
  int     m_rate  = 0;

  function automatic int par7(bit [6:0] r, bit [6:0] g);
    int x = 0;
    for (int i = 0; i < 7; i++) x = x ^ int'(r[i] & g[i]);
    return x;
  endfunction

  function automatic int ref_metric(int c, int s, bit e);
    if (e) return 0;
    return (c != 0) ? 7 - s : s;
  endfunction

  function automatic int ref_bm(int p, int b, step_t st);
    bit [6:0] r = 7'(b * 64 + p);
    return ref_metric(par7(r, 7'o171), st.s0, st.e0) + ref_metric(par7(r, 7'o133), st.s1, st.e1);
  endfunction

  // Reference depuncturer: pattern strings read left to right, one character per phase.
  task automatic model_accept(int s);
    int       per;
    bit [2:0] pat0;
    bit [2:0] pat1;
    bit       u0;
    bit       u1;
    step_t    st;
    if (m_phase == 0 && !m_held) m_rate = (rate_i == 2'b11) ? 0 : int'(rate_i);
    case (m_rate)
      1:       begin per = 2; pat0 = 3'b011; pat1 = 3'b010; end
      2:       begin per = 3; pat0 = 3'b101; pat1 = 3'b110; end
      default: begin per = 1; pat0 = 3'b001; pat1 = 3'b001; end
    endcase
    u0 = pat0[per - 1 - m_phase];
    u1 = pat1[per - 1 - m_phase];
    if (!m_held && u0 && u1) begin
      m_held = 1;
      m_hsym = s;
    end else begin
      st.s0 = m_held ? m_hsym : (u0 ? s : 0);
      st.e0 = !m_held && !u0;
      st.s1 = (m_held || u1) ? s : 0;
      st.e1 = !m_held && !u1;
      st.at = cyc + 2;
      sb_q.push_back(st);
      m_held  = 0;
      m_phase = (m_phase + 1) % per;
    end
  endtask

  task automatic step_clk();
    step_t st;
    int    bad_p;
    int    bad_b;
    int    got;
    int    want;
    @(posedge clk_i);
    cyc++;
    #1;
    if (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse cycle %0d: valid_o=0, required 1 at cycle %0d", cyc, sb_q[0].at);
      void'(sb_q.pop_front());
    end
    if (valid_o === 1'b1) begin
      pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle %0d: valid_o=1, required 0", cyc);
      end else begin
        st = sb_q.pop_front();
        bad_p = -1;
        bad_b = 0;
        got = 0;
        want = 0;
        for (int p = 0; p < STATES_N && bad_p < 0; p++) begin
          for (int b = 0; b < 2 && bad_p < 0; b++) begin
            got  = (b == 0) ? int'(bm0_o[p*BM_BITS +: BM_BITS]) : int'(bm1_o[p*BM_BITS +: BM_BITS]);
            want = ref_bm(p, b, st);
            if (got != want) begin
              bad_p = p;
              bad_b = b;
            end
          end
        end
        if (st.at != cyc) begin
          errors++;
          $display("FAIL pulse_latency: pulse at cycle %0d, required cycle %0d", cyc, st.at);
        end else if (bad_p >= 0) begin
          errors++;
          $display("FAIL bm_value: bm%0d[%0d]=%0d, required %0d (cycle %0d)", bad_b, bad_p, got, want, cyc);
        end else begin
          $display("pulse cycle %0d bm0[0]=%0d bm1[0]=%0d", cyc, bm0_o[0 +: BM_BITS], bm1_o[0 +: BM_BITS]);
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step_clk();
  endtask

  task automatic beat(int s);
    sym_i       = SOFT_BITS'(s);
    sym_valid_i = 1'b1;
    model_accept(s);
    step_clk();
    sym_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; rate_i = 2'b00; sym_i = '0; sym_valid_i = 1'b0;
    #2;
    checks++;
    if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", sym_ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    checks++;
    if (bm0_o !== '0 || bm1_o !== '0) begin errors++; $display("FAIL reset_bm: got nonzero metrics, required 0"); end
    step_clk();
    #3 rst_ni = 1'b1;
    step_clk();
    checks++;
    if (sym_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b, required 1", sym_ready_o); end
  endtask

  task automatic test_rate12();
    int p0;
    rate_i = 2'b00;
    p0 = pulses;
    beat(0); beat(0); idle(2);
    checks++;
    if (pulses - p0 != 1) begin errors++; $display("FAIL r12_pulses: got %0d, required 1", pulses - p0); end
    checks++;
    if (bm0_o[0 +: BM_BITS] !== 4'd0 || bm1_o[0 +: BM_BITS] !== 4'd14) begin
      errors++; $display("FAIL r12_zero: bm0[0]=%0d bm1[0]=%0d, required 0/14", bm0_o[0 +: BM_BITS], bm1_o[0 +: BM_BITS]);
    end
    beat(7); beat(7); idle(2);
    checks++;
    if (bm0_o[0 +: BM_BITS] !== 4'd14 || bm1_o[0 +: BM_BITS] !== 4'd0) begin
      errors++; $display("FAIL r12_seven: bm0[0]=%0d bm1[0]=%0d, required 14/0", bm0_o[0 +: BM_BITS], bm1_o[0 +: BM_BITS]);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    rate_i = 2'b00;
    p0 = pulses;
    repeat (100) beat(int'($urandom_range(0, 7)));
    idle(2);
    checks++;
    if (pulses - p0 != 50) begin errors++; $display("FAIL b2b_pulses: got %0d, required 50", pulses - p0); end
  endtask

  task automatic test_rate23();
    int p0;
    rate_i = 2'b01;
    p0 = pulses;
    beat(0); beat(0); beat(7); idle(2);
    checks++;
    if (pulses - p0 != 2) begin errors++; $display("FAIL r23_pulses: got %0d, required 2", pulses - p0); end
    checks++;
    if (bm0_o[0 +: BM_BITS] !== 4'd7 || bm1_o[0 +: BM_BITS] !== 4'd0) begin
      errors++; $display("FAIL r23_erased: bm0[0]=%0d bm1[0]=%0d, required 7/0", bm0_o[0 +: BM_BITS], bm1_o[0 +: BM_BITS]);
    end
    p0 = pulses;
    repeat (3) beat(int'($urandom_range(0, 7)));
    idle(2);
    checks++;
    if (pulses - p0 != 2) begin errors++; $display("FAIL r23_wrap: got %0d, required 2", pulses - p0); end
  endtask

  task automatic test_rate34();
    int p0;
    int big;
    rate_i = 2'b10;
    p0 = pulses;
    repeat (3) beat(3);
    idle(2);
    for (int phase = 0; phase < 2; phase++) begin
      big = 0;
      for (int p = 0; p < STATES_N; p++)
        if (bm0_o[p*BM_BITS +: BM_BITS] > 4 || bm1_o[p*BM_BITS +: BM_BITS] > 4) big++;
      checks++;
      if (big != 0) begin errors++; $display("FAIL r34_erased_bound: %0d states above 4, required 0", big); end
      if (phase == 0) begin beat(3); idle(2); end
    end
    repeat (2) beat(3);
    idle(2);
    checks++;
    if (pulses - p0 != 4) begin errors++; $display("FAIL r34_pulses: got %0d, required 4", pulses - p0); end
    p0 = pulses;
    beat(3);
    rate_i = 2'b00;
    beat(1); beat(2); beat(4); idle(2);
    checks++;
    if (pulses - p0 != 3) begin errors++; $display("FAIL rate_hold: got %0d pulses, required 3", pulses - p0); end
    beat(5); beat(6); idle(2);
    checks++;
    if (pulses - p0 != 4) begin errors++; $display("FAIL rate_switch: got %0d pulses, required 4", pulses - p0); end
  endtask

  task automatic test_flush();
    int p0;
    rate_i = 2'b00;
    p0 = pulses;
    beat(5);
    sym_i = 3'd7; sym_valid_i = 1'b1; flush_i = 1'b1;
    m_held = 0; m_phase = 0;
    step_clk();
    flush_i = 1'b0; sym_valid_i = 1'b0;
    idle(2);
    checks++;
    if (pulses - p0 != 0) begin errors++; $display("FAIL flush_discard: got %0d pulses, required 0", pulses - p0); end
    beat(0); beat(0); idle(2);
    checks++;
    if (pulses - p0 != 1 || bm0_o[0 +: BM_BITS] !== 4'd0) begin
      errors++; $display("FAIL flush_restart: pulses %0d bm0[0]=%0d, required 1/0", pulses - p0, bm0_o[0 +: BM_BITS]);
    end
    p0 = pulses;
    beat(2); beat(3);
    flush_i = 1'b1;
    m_held = 0; m_phase = 0;
    step_clk();
    flush_i = 1'b0;
    idle(2);
    checks++;
    if (pulses - p0 != 1) begin errors++; $display("FAIL flush_keeps_ready: got %0d pulses, required 1", pulses - p0); end
  endtask

  task automatic test_reset_mid();
    int p0;
    rate_i = 2'b00;
    beat(4);
    #3 rst_ni = 1'b0;
    m_held = 0; m_phase = 0; m_rate = 0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || sym_ready_o !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctrl: valid_o=%b sym_ready_o=%b, required 0/0", valid_o, sym_ready_o);
    end
    checks++;
    if (bm0_o !== '0 || bm1_o !== '0) begin errors++; $display("FAIL async_reset_bm: got nonzero metrics, required 0"); end
    step_clk();
    #2 rst_ni = 1'b1;
    p0 = pulses;
    idle(3);
    checks++;
    if (pulses - p0 != 0) begin errors++; $display("FAIL stale_after_reset: got %0d pulses, required 0", pulses - p0); end
    beat(7); beat(7); idle(2);
    checks++;
    if (pulses - p0 != 1 || bm0_o[0 +: BM_BITS] !== 4'd14) begin
      errors++; $display("FAIL post_reset_step: pulses %0d bm0[0]=%0d, required 1/14", pulses - p0, bm0_o[0 +: BM_BITS]);
    end
  endtask

  initial begin
    test_reset();
    test_rate12();
    test_back_to_back();
    test_rate23();
    test_rate34();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL leftover_steps: %0d pending, required 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
